// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// controller state encoding, Booth group codes and the multiplicand guard width.
package booth_pkg;

  // Extra multiplicand bits so that +/-2A cannot overflow the partial product.
  localparam int GUARD_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Radix-4 Booth group codes: {b[2i+1], b[2i], b[2i-1]}.
  localparam logic [2:0] GRP_ZERO_P  = 3'b000;
  localparam logic [2:0] GRP_PLUS_1A = 3'b001;
  localparam logic [2:0] GRP_PLUS_1B = 3'b010;
  localparam logic [2:0] GRP_PLUS_2  = 3'b011;
  localparam logic [2:0] GRP_MINUS_2 = 3'b100;
  localparam logic [2:0] GRP_MINUS_1A = 3'b101;
  localparam logic [2:0] GRP_MINUS_1B = 3'b110;
  localparam logic [2:0] GRP_ZERO_N  = 3'b111;

endpackage : booth_pkg

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: maps one 3-bit group code and the
// guarded multiplicand to 0, +/-A or +/-2A, WIDTH+GUARD_W bits wide.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]               code,
  input  logic [WIDTH+GUARD_W-1:0] mcand,
  output logic [WIDTH+GUARD_W-1:0] pp
);

  localparam int PP_W = WIDTH + GUARD_W;

  logic [PP_W-1:0] mcand_x2;

  assign mcand_x2 = {mcand[PP_W-2:0], 1'b0};

  // Decode the Booth group into the signed partial product.
  always_comb begin
    // NOTE: default assignment first so every path drives pp; no latch can be inferred.
    pp = '0;
    case (code)
      GRP_ZERO_P, GRP_ZERO_N:     pp = '0;
      GRP_PLUS_1A, GRP_PLUS_1B:   pp = mcand;
      GRP_PLUS_2:                 pp = mcand_x2;
      GRP_MINUS_2:                pp = -mcand_x2;
      GRP_MINUS_1A, GRP_MINUS_1B: pp = -mcand;
      default:                    pp = '0;
    endcase
  end

endmodule : booth_pp_sel

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth signed multiplier, two multiplier bits per cycle.
// IDLE -> RUN (WIDTH/2 iterations) -> DONE (one-cycle done pulse) -> IDLE.
// Optional build macro BOOTH_EARLY_EXIT_EN: leave RUN as soon as every
// remaining Booth group decodes to zero (remaining multiplier bits all equal).
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int MC_W  = WIDTH + GUARD_W;
  localparam int MP_W  = WIDTH + 1;
  localparam int P_W   = 2 * WIDTH;
  localparam int ITERS = WIDTH / 2;
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_seq_mult: WIDTH must be even and >= 4");
  end

  state_t            state;
  logic [MC_W-1:0]   mcand;
  logic [MP_W-1:0]   mplier;
  logic [P_W-1:0]    acc;
  logic [CNT_W-1:0]  cnt;

  logic [MC_W-1:0]   pp;
  logic [P_W-1:0]    pp_ext;
  logic [P_W-1:0]    acc_nxt;
  logic [MP_W-1:0]   mplier_nxt;
  logic              last_iter;

  booth_pp_sel #(
    .WIDTH (WIDTH)
  ) u_pp_sel (
    .code  (mplier[2:0]),
    .mcand (mcand),
    .pp    (pp)
  );

  // Next accumulator / multiplier values and end-of-run detection.
  always_comb begin
    pp_ext     = {{(P_W-MC_W){pp[MC_W-1]}}, pp} << {cnt, 1'b0};
    acc_nxt    = acc + pp_ext;
    mplier_nxt = {{2{mplier[MP_W-1]}}, mplier[MP_W-1:2]};
    last_iter  = (cnt == LAST_CNT);
`ifdef BOOTH_EARLY_EXIT_EN
    // All-equal remaining bits mean every later group is 000 or 111.
    if ((mplier_nxt == '0) || (&mplier_nxt)) begin
      last_iter = 1'b1;
    end
`else
`endif
  end

  // Controller and datapath registers, including registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so an aborted run leaves nothing behind.
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments; every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= {{GUARD_W{a[WIDTH-1]}}, a};
            mplier <= {b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            p     <= acc_nxt;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : booth_seq_mult

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be even and >= 4.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset; sampled on the CLK rising edge only.
REQ-004 START  input  1  request pulse; accepted only in IDLE.
REQ-005 A  input  WIDTH  signed multiplicand; sampled on the START acceptance edge.
REQ-006 B  input  WIDTH  signed multiplier; sampled on the START acceptance edge.
REQ-007 BUSY  output  1  high in RUN and DONE states.
REQ-008 DONE  output  1  one-cycle pulse; P is valid when it is high.
REQ-009 P  output  2*WIDTH  signed product; held from DONE until the next accepted START.

Function
REQ-010 States: IDLE, RUN, DONE.
REQ-011 Transitions: IDLE->RUN on START; RUN->DONE after the final iteration; DONE->IDLE unconditionally.
REQ-012 On acceptance, the block SHALL perform the following loads:
- Multiplicand register: A sign-extended to WIDTH+2 bits.
- Multiplier shift register: {B, 1'b0}.
- Accumulator: cleared.
- Iteration counter: cleared.
REQ-013 Each RUN cycle SHALL decode the 3-bit Booth group (multiplier register bits [2:0]) to a partial product:
- 000 and 111 -> 0.
- 001 and 010 -> +A.
- 011 -> +2A.
- 100 -> -2A.
- 101 and 110 -> -A.
No code SHALL produce X.
REQ-014 Each RUN cycle SHALL add the partial product, sign-extended and shifted left by 2*i, to the 2*WIDTH accumulator, then arithmetic-shift the multiplier register right by 2 and increment i.
REQ-015 RUN SHALL last exactly WIDTH/2 cycles; DONE SHALL assert on the (WIDTH/2+1)th edge after the START acceptance edge (5 for WIDTH=8).
REQ-016 P SHALL equal A*B exactly (two's complement, modulo 2^(2*WIDTH)) for all inputs, including A = B = -2^(WIDTH-1).
REQ-017 START while BUSY (RUN or DONE) SHALL be ignored; A and B are not re-sampled.
REQ-018 START held high continuously SHALL launch a new operation on the first IDLE cycle after DONE.
REQ-019 P SHALL update only on the DONE transition; it SHALL never show intermediate accumulator values.

Reset
REQ-020 With RST high at an edge:
- state SHALL become IDLE;
- BUSY, DONE and P SHALL be 0;
- the accumulator, multiplier register and counter SHALL be 0.
REQ-021 RST SHALL take priority over START.
REQ-022 RST mid-RUN SHALL abort the operation with no DONE pulse.
REQ-023 The first START SHALL be accepted on the first edge after RST deasserts.

Configuration
REQ-024 Macro BOOTH_EARLY_EXIT_EN.
- Defined: RUN SHALL go to DONE after any iteration where the remaining multiplier register bits are all equal (all remaining groups decode to 0). The product SHALL be unchanged; minimum latency is 2 edges.
- Undefined: latency SHALL be fixed per REQ-015.

Structure
REQ-025 Package booth_pkg SHALL hold:
- the state enum;
- the Booth group code constants;
- a localparam for the guard width (2 bits).
REQ-026 Sub-module booth_pp_sel (combinational, group code + multiplicand -> WIDTH+2 bit partial product) SHALL implement REQ-013. It is instantiated once.

Verification
REQ-027 A=7, B=-3, WIDTH=8 -> DONE on the 5th edge after START, P=16'hFFEB.
REQ-028 A=-128, B=-128 -> P=16'h4000.
REQ-029 A=127, B=-128 -> P=16'hC080.
REQ-030 Start A=5, B=9; pulse START again on edge 2 with A=1, B=1 -> second START ignored; P=16'h002D; exactly one DONE.
REQ-031 Start, then assert RST on edge 3 -> no DONE; P=0, BUSY=0 next cycle; a new START A=-1, B=-1 -> P=16'h0001.
REQ-032 B=0, A=55:
- macro defined -> DONE on the 2nd edge, P=0;
- macro undefined -> DONE on the 5th edge, P=0.

Also run a random sweep of 10k operand pairs against a reference model.
